// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared Y86-64 encodings for the fetch controller: instruction codes,
// processor status codes, fetch FSM states and the longest instruction span.
package pc_fetch_ctrl_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_t;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // Longest Y86-64 instruction in bytes; a fetch reads up to this many bytes.
  localparam int unsigned IFETCH_SPAN = 10;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Request/acknowledge bus between the fetch controller and instruction memory.
interface pc_fetch_ctrl_if;

  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i;
  logic        imem_err_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_err_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_err_i
  );

endinterface

// File: rtl/pc_fetch_ctrl_imem_wait_timer.sv
// Counts FETCH cycles spent waiting for an instruction-memory acknowledge and
// flags expiry in the MAX_WAIT-th waiting cycle.
module pc_fetch_ctrl_imem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [7:0] count_q;

  assign expire_o = (count_q == 8'(MAX_WAIT - 1));

  // Clear outside FETCH so every fetch starts at zero; saturate at the limit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i && !expire_o) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer for the single-issue Y86-64 core.
// Optional macro IADDR_CHECK_EN: refuse to fetch from an address whose
// instruction span would run past IMEM_BYTES, halting with ADR instead.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 4096,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  pc_fetch_ctrl_if.master imem,
  output logic            instr_valid_o,
  input  logic [3:0]      icode_i,
  input  logic            pc_next_valid_i,
  input  logic [63:0]     pc_next_i,
  output logic [63:0]     pc_o,
  output logic [2:0]      stat_o,
  output logic            busy_o
);

`ifdef IADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  fetch_state_t state_q, state_d;
  stat_t        stat_q, stat_d;
  logic [63:0]  pc_q, pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         timer_expire;
  logic         retire;
  logic [63:0]  fetch_target;
  logic         fetch_target_ok;

  // The pulse cycle of EXEC never retires; the earliest retire is the cycle after.
  assign retire = (state_q == ST_EXEC) && !instr_valid_q && pc_next_valid_i;

  // Address the next FETCH would use: the retiring next PC, or the held PC from IDLE.
  assign fetch_target = (state_q == ST_EXEC) ? pc_next_i : pc_q;

  // 65-bit sum so an address near the top of the space cannot wrap past the check.
  assign fetch_target_ok = !ADDR_CHECK ||
    (({1'b0, fetch_target} + 65'(IFETCH_SPAN)) <= 65'(IMEM_BYTES));

  pc_fetch_ctrl_imem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_imem_wait_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (state_q != ST_FETCH),
    .enable_i ((state_q == ST_FETCH) && !imem.imem_ack_i),
    .expire_o (timer_expire)
  );

  // State register together with the PC, status and decode-pulse registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      stat_q        <= SAOK;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stat_q        <= stat_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state logic: fetch handshake, timeout, retire and fault classification.
  always_comb begin
    state_d       = state_q;
    stat_d        = stat_q;
    pc_d          = pc_q;
    instr_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (fetch_target_ok) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HALT;
            stat_d  = SADR;
          end
        end
      end
      ST_FETCH: begin
        if (imem.imem_ack_i) begin
          if (imem.imem_err_i) begin
            state_d = ST_HALT;
            stat_d  = SADR;
          end else begin
            state_d       = ST_EXEC;
            instr_valid_d = 1'b1;
          end
        end else if (timer_expire) begin
          state_d = ST_HALT;
          stat_d  = SADR;
        end
      end
      ST_EXEC: begin
        if (retire) begin
          if (icode_i == IHALT) begin
            state_d = ST_HALT;
            stat_d  = SHLT;
          end else if (icode_i > IPOPQ) begin
            state_d = ST_HALT;
            stat_d  = SINS;
          end else begin
            pc_d = pc_next_i;
            if (fetch_target_ok) begin
              state_d = ST_FETCH;
            end else begin
              state_d = ST_HALT;
              stat_d  = SADR;
            end
          end
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Outputs decoded from the current state so an async reset drops the request at once.
  always_comb begin
    imem.imem_req_o  = (state_q == ST_FETCH);
    imem.imem_addr_o = (state_q == ST_FETCH) ? pc_q : 64'd0;
    busy_o           = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    instr_valid_o    = instr_valid_q;
    pc_o             = pc_q;
    stat_o           = stat_q;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl (RESET_PC=0x100, IMEM_BYTES=4096, MAX_WAIT=15).
// Expected values are hand-computed; the IADDR_CHECK_EN build selects the
// alternative expectations for the bounds-check scenarios.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        instr_valid_o;
  logic [3:0]  icode_i;
  logic        pc_next_valid_i;
  logic [63:0] pc_next_i;
  logic [63:0] pc_o;
  logic [2:0]  stat_o;
  logic        busy_o;
  int          n_checks = 0;
  int          n_fail   = 0;

  pc_fetch_ctrl_if imem_bus();

  pc_fetch_ctrl #(
    .RESET_PC   (RST_PC),
    .IMEM_BYTES (4096),
    .MAX_WAIT   (15)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .start_i         (start_i),
    .imem            (imem_bus.master),
    .instr_valid_o   (instr_valid_o),
    .icode_i         (icode_i),
    .pc_next_valid_i (pc_next_valid_i),
    .pc_next_i       (pc_next_i),
    .pc_o            (pc_o),
    .stat_o          (stat_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_n_i             = 1'b0;
    start_i             = 1'b0;
    imem_bus.imem_ack_i = 1'b0;
    imem_bus.imem_err_i = 1'b0;
    pc_next_valid_i     = 1'b0;
    pc_next_i           = 64'd0;
    icode_i             = 4'd0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    tick();
  endtask

  // From IDLE: one start cycle, then the DUT sits in FETCH at pc_o.
  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // From FETCH: same-cycle ack, pass the pulse cycle, retire with the given next PC/icode.
  task automatic run_instr(input logic [63:0] npc, input logic [3:0] ic);
    imem_bus.imem_ack_i = 1'b1;
    tick();
    imem_bus.imem_ack_i = 1'b0;
    tick();
    pc_next_valid_i = 1'b1;
    pc_next_i       = npc;
    icode_i         = ic;
    tick();
    pc_next_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (pc_o !== RST_PC) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pc_o, RST_PC); end
    n_checks++; if (imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", imem_bus.imem_req_o); end
    n_checks++; if (imem_bus.imem_addr_o !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_bus.imem_addr_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid_o); end
    n_checks++; if (stat_o !== 3'd1) begin n_fail++; $display("[TB] FAIL reset_stat: got %0d expected 1", stat_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    do_start();
    n_checks++; if (imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_req: got %b expected 1", imem_bus.imem_req_o); end
    n_checks++; if (imem_bus.imem_addr_o !== 64'h100) begin n_fail++; $display("[TB] FAIL basic_addr: got %h expected 100", imem_bus.imem_addr_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy: got %b expected 1", busy_o); end
    imem_bus.imem_ack_i = 1'b1;
    tick();
    imem_bus.imem_ack_i = 1'b0;
    n_checks++; if (imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_req_drop: got %b expected 0", imem_bus.imem_req_o); end
    n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_pulse: got %b expected 1", instr_valid_o); end
    // Retire offered during the pulse cycle must be ignored for one edge.
    pc_next_valid_i = 1'b1;
    pc_next_i       = 64'h10A;
    icode_i         = IIRMOVQ;
    tick();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_pulse_end: got %b expected 0", instr_valid_o); end
    n_checks++; if (pc_o !== 64'h100) begin n_fail++; $display("[TB] FAIL basic_pc_hold: got %h expected 100", pc_o); end
    tick();
    pc_next_valid_i = 1'b0;
    n_checks++; if (pc_o !== 64'h10A) begin n_fail++; $display("[TB] FAIL basic_pc_next: got %h expected 10a", pc_o); end
    n_checks++; if (imem_bus.imem_addr_o !== 64'h10A) begin n_fail++; $display("[TB] FAIL basic_next_addr: got %h expected 10a", imem_bus.imem_addr_o); end
    n_checks++; if (imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_next_req: got %b expected 1", imem_bus.imem_req_o); end
  endtask

  task automatic test_delayed_ack();
    int pulses;
    apply_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({imem_bus.imem_req_o, imem_bus.imem_addr_o} !== {1'b1, 64'h100}) begin n_fail++; $display("[TB] FAIL delay_stable[%0d]: got req=%b addr=%h expected req=1 addr=100", i, imem_bus.imem_req_o, imem_bus.imem_addr_o); end
      tick();
    end
    imem_bus.imem_ack_i = 1'b1;
    tick();
    imem_bus.imem_ack_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (instr_valid_o === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL delay_pulses: got %0d expected 1", pulses); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL delay_busy_exec: got %b expected 1", busy_o); end
  endtask

  task automatic test_timeout();
    apply_reset();
    do_start();
    repeat (14) tick();
    n_checks++; if (imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_cycle15_req: got %b expected 1", imem_bus.imem_req_o); end
    n_checks++; if (stat_o !== 3'd1) begin n_fail++; $display("[TB] FAIL timeout_cycle15_stat: got %0d expected 1", stat_o); end
    tick();
    n_checks++; if (stat_o !== 3'd3) begin n_fail++; $display("[TB] FAIL timeout_stat: got %0d expected 3", stat_o); end
    n_checks++; if (imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_req: got %b expected 0", imem_bus.imem_req_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy_o); end
    start_i             = 1'b1;
    imem_bus.imem_ack_i = 1'b1;
    repeat (3) tick();
    start_i             = 1'b0;
    imem_bus.imem_ack_i = 1'b0;
    n_checks++; if ({stat_o, imem_bus.imem_req_o, instr_valid_o, busy_o} !== {3'd3, 3'b000}) begin n_fail++; $display("[TB] FAIL timeout_sticky: got stat=%0d req=%b valid=%b busy=%b expected 3/0/0/0", stat_o, imem_bus.imem_req_o, instr_valid_o, busy_o); end
  endtask

  task automatic test_halt_icode();
    apply_reset();
    do_start();
    run_instr(64'h20, INOP);
    n_checks++; if (imem_bus.imem_addr_o !== 64'h20) begin n_fail++; $display("[TB] FAIL halt_fetch_addr: got %h expected 20", imem_bus.imem_addr_o); end
    run_instr(64'h22, IHALT);
    n_checks++; if (stat_o !== 3'd2) begin n_fail++; $display("[TB] FAIL halt_stat: got %0d expected 2", stat_o); end
    n_checks++; if (pc_o !== 64'h20) begin n_fail++; $display("[TB] FAIL halt_pc: got %h expected 20", pc_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_busy: got %b expected 0", busy_o); end
    pc_next_valid_i = 1'b1;
    pc_next_i       = 64'h40;
    icode_i         = INOP;
    start_i         = 1'b1;
    repeat (2) tick();
    pc_next_valid_i = 1'b0;
    start_i         = 1'b0;
    n_checks++; if ({pc_o, stat_o} !== {64'h20, 3'd2}) begin n_fail++; $display("[TB] FAIL halt_sticky: got pc=%h stat=%0d expected pc=20 stat=2", pc_o, stat_o); end
  endtask

  task automatic test_illegal_icode();
    apply_reset();
    do_start();
    run_instr(64'h200, IPOPQ);
    n_checks++; if (imem_bus.imem_addr_o !== 64'h200) begin n_fail++; $display("[TB] FAIL popq_legal_addr: got %h expected 200", imem_bus.imem_addr_o); end
    n_checks++; if (stat_o !== 3'd1) begin n_fail++; $display("[TB] FAIL popq_legal_stat: got %0d expected 1", stat_o); end
    run_instr(64'h300, 4'hC);
    n_checks++; if (stat_o !== 3'd4) begin n_fail++; $display("[TB] FAIL ins_stat: got %0d expected 4", stat_o); end
    n_checks++; if (pc_o !== 64'h200) begin n_fail++; $display("[TB] FAIL ins_pc: got %h expected 200", pc_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ins_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_imem_err();
    apply_reset();
    do_start();
    imem_bus.imem_ack_i = 1'b1;
    imem_bus.imem_err_i = 1'b1;
    tick();
    imem_bus.imem_ack_i = 1'b0;
    imem_bus.imem_err_i = 1'b0;
    n_checks++; if (stat_o !== 3'd3) begin n_fail++; $display("[TB] FAIL err_stat: got %0d expected 3", stat_o); end
    n_checks++; if ({imem_bus.imem_req_o, instr_valid_o, busy_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL err_outputs: got req=%b valid=%b busy=%b expected 0/0/0", imem_bus.imem_req_o, instr_valid_o, busy_o); end
  endtask

  task automatic test_addr_bounds();
    apply_reset();
    do_start();
    run_instr(64'hFF6, INOP);
    n_checks++; if ({imem_bus.imem_req_o, imem_bus.imem_addr_o} !== {1'b1, 64'hFF6}) begin n_fail++; $display("[TB] FAIL bound_ff6: got req=%b addr=%h expected req=1 addr=ff6", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    run_instr(64'hFF8, INOP);
`ifdef IADDR_CHECK_EN
    n_checks++; if ({stat_o, imem_bus.imem_req_o, pc_o} !== {3'd3, 1'b0, 64'hFF8}) begin n_fail++; $display("[TB] FAIL bound_ff8: got stat=%0d req=%b pc=%h expected stat=3 req=0 pc=ff8", stat_o, imem_bus.imem_req_o, pc_o); end
    repeat (2) tick();
    n_checks++; if (imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bound_ff8_noreq: got %b expected 0", imem_bus.imem_req_o); end
`else
    n_checks++; if ({stat_o, imem_bus.imem_req_o, imem_bus.imem_addr_o} !== {3'd1, 1'b1, 64'hFF8}) begin n_fail++; $display("[TB] FAIL bound_ff8: got stat=%0d req=%b addr=%h expected stat=1 req=1 addr=ff8", stat_o, imem_bus.imem_req_o, imem_bus.imem_addr_o); end
`endif
  endtask

  task automatic test_full_width();
    apply_reset();
    do_start();
    run_instr(64'hFFFF_FFFF_FFFF_FFFF, IRRMOVQ);
    n_checks++; if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("[TB] FAIL wide_pc: got %h expected ffffffffffffffff", pc_o); end
`ifdef IADDR_CHECK_EN
    n_checks++; if ({stat_o, imem_bus.imem_req_o} !== {3'd3, 1'b0}) begin n_fail++; $display("[TB] FAIL wide_check: got stat=%0d req=%b expected stat=3 req=0", stat_o, imem_bus.imem_req_o); end
`else
    n_checks++; if ({imem_bus.imem_req_o, imem_bus.imem_addr_o} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin n_fail++; $display("[TB] FAIL wide_addr: got req=%b addr=%h expected req=1 addr=ffffffffffffffff", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_start();
    run_instr(64'h300, INOP);
    n_checks++; if (imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL async_pre_req: got %b expected 1", imem_bus.imem_req_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_checks++; if (imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL async_req_drop: got %b expected 0", imem_bus.imem_req_o); end
    n_checks++; if ({pc_o, busy_o} !== {RST_PC, 1'b0}) begin n_fail++; $display("[TB] FAIL async_pc_busy: got pc=%h busy=%b expected pc=100 busy=0", pc_o, busy_o); end
    tick();
    rst_n_i = 1'b1;
    tick();
    n_checks++; if ({pc_o, stat_o, imem_bus.imem_req_o, imem_bus.imem_addr_o, instr_valid_o, busy_o} !== {RST_PC, 3'd1, 1'b0, 64'd0, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL async_after: got pc=%h stat=%0d req=%b addr=%h valid=%b busy=%b expected 100/1/0/0/0/0", pc_o, stat_o, imem_bus.imem_req_o, imem_bus.imem_addr_o, instr_valid_o, busy_o); end
  endtask

  initial begin
    $display("[TB] pc_fetch_ctrl directed test");
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_timeout();
    test_halt_icode();
    test_illegal_icode();
    test_imem_err();
    test_addr_bounds();
    test_full_width();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequential PC register and instruction-fetch sequencer for the single-issue Y86-64 core.
- Holds the architectural PC and issues a request/acknowledge fetch to instruction memory.
- Accepts the next PC computed by the PC-update stage and tracks processor status (AOK/HLT/ADR/INS).
- Sits at the consuming end of the next-PC path: it registers the next PC and starts the next fetch from it.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_BYTES, 4096, instruction memory size in bytes; used only by the optional bounds check.
- MAX_WAIT, 15, FETCH cycles without imem_ack_i before fetch timeout (1..255).

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_n_i  in  1  asynchronous reset, active-low.
- start_i  in  1  begin execution from pc_o; honoured only in IDLE.
- imem_req_o  out  1  fetch request, held until ack.
- imem_addr_o  out  64  fetch byte address.
- imem_ack_i  in  1  fetch done; instruction bytes valid at memory side this cycle.
- imem_err_i  in  1  fetch fault; qualified by imem_ack_i.
- instr_valid_o  out  1  one-cycle pulse: fetched instruction ready for decode.
- icode_i  in  4  icode of the current instruction from decode (define.v encodings).
- pc_next_valid_i  in  1  pc_next_i valid; instruction retired.
- pc_next_i  in  64  next PC from the PC-update stage.
- pc_o  out  64  architectural PC of the current instruction.
- stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy_o  out  1  high in FETCH or EXEC.

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-low.
- Reset values:
  - Outputs: state=IDLE, pc_o=RESET_PC, imem_req_o=0, imem_addr_o=0, instr_valid_o=0, stat_o=AOK, busy_o=0.
  - Internal: wait counter=0.
- Reset mid-operation drops imem_req_o immediately (asynchronous); no partial state survives.
- States: IDLE, FETCH, EXEC, HALT (encodings in define.v).
- IDLE:
  - start_i=1 -> FETCH next cycle.
  - On entering FETCH: imem_req_o=1, imem_addr_o=pc_o, counter=0.
- FETCH:
  - imem_req_o and imem_addr_o are held stable until ack.
  - imem_ack_i=1 and imem_err_i=0 -> EXEC. Next cycle: imem_req_o=0, instr_valid_o=1 for exactly that one cycle.
  - imem_ack_i=1 and imem_err_i=1 -> HALT, stat_o=ADR, imem_req_o=0.
  - No ack: counter increments. Counter==MAX_WAIT-1 with no ack -> HALT, stat_o=ADR. Timeout therefore fires in the MAX_WAIT-th cycle of FETCH.
- EXEC:
  - Wait for pc_next_valid_i. The earliest accepted cycle is the one after the instr_valid_o pulse.
  - On pc_next_valid_i with icode_i==IHALT: stat_o=HLT, HALT. pc_o is unchanged and keeps the halt instruction address.
  - On pc_next_valid_i with icode_i > IPOPQ (4'hB): stat_o=INS, HALT. pc_o is unchanged.
  - Otherwise: pc_o<=pc_next_i, then FETCH from the new PC next cycle (imem_addr_o=pc_next_i).
- HALT: sticky until reset; all inputs ignored; busy_o=0.
- Ignored inputs:
  - imem_ack_i outside FETCH.
  - pc_next_valid_i outside EXEC.
  - start_i outside IDLE.
- Timing: minimum 3 cycles per instruction (FETCH with same-cycle ack, EXEC with pulse, EXEC accept).
- Arithmetic: pc_o is full 64-bit with no wrap handling. pc_next_i=64'hFFFF_FFFF_FFFF_FFFF is accepted as is.

Optional Feature:
- Macro IADDR_CHECK_EN.
- Defined: on every entry into FETCH, if addr+10 > IMEM_BYTES (unsigned, computed in 65 bits), go to HALT with stat_o=ADR and never assert imem_req_o. pc_o is set to the offending address.
- Undefined: no check; any address is issued to memory.

Decomposition:
- Shared define.v holds the icode constants (IHALT..IPOPQ, already present) plus new ones:
  - Status codes SAOK/SHLT/SADR/SINS.
  - FSM state encodings.
- One sub-module is natural: imem_wait_timer (counter with clear/enable/expire for MAX_WAIT).

Test Plan:
- Reset with RESET_PC=64'h100, then start_i pulse -> next cycle imem_req_o=1, imem_addr_o=64'h100; ack same cycle -> instr_valid_o pulses once; pc_next_valid_i with pc_next_i=64'h10A, icode=IIRMOVQ -> next fetch at 64'h10A.
- Ack delayed 5 cycles -> imem_req_o and imem_addr_o stable all 5 cycles; exactly one instr_valid_o pulse after the ack.
- No ack for 15 cycles (MAX_WAIT=15) -> stat_o=3, HALT, imem_req_o=0; a later start_i and imem_ack_i have no effect.
- icode_i=IHALT with pc_next_valid_i, pc_o=64'h20 -> stat_o=2, pc_o stays 64'h20, busy_o=0; icode_i=4'hD -> stat_o=4.
- imem_err_i with ack -> stat_o=3. With IADDR_CHECK_EN, IMEM_BYTES=4096, pc_next_i=64'hFF8 -> HALT with ADR and no imem_req_o assertion.
- rst_n_i asserted mid-FETCH -> imem_req_o falls without waiting for a clock edge; after release, all outputs hold their reset values.
